xeng_acc_unload: RTL and testbench

Downstream stage of the X-engine dual-pol complex MAC. It captures each completed accumulation vector (XX, YY, XY, YX complex results) when the MAC's valid strobe fires, then buffers the vector in a small FIFO. It narrows each real/imag part to an output width and serialises the vector as four complex beats on a valid/ready stream, with baseline tagging, towards the X-engine output packetiser.

---
 rtl/xeng_pkg.sv | 18 +
 rtl/xeng_sync_fifo.sv | 60 ++++++
 rtl/xeng_acc_unload.sv | 159 +++++++++++++++
 tb/tb_xeng_acc_unload.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: accumulator width derivation and product indices.
// Used by the dual-pol MAC and by its unload stage.
package xeng_pkg;

    localparam logic [1:0] POL_XX = 2'd0;
    localparam logic [1:0] POL_YY = 2'd1;
    localparam logic [1:0] POL_XY = 2'd2;
    localparam logic [1:0] POL_YX = 2'd3;

    // Product of two BITWIDTH samples, one bit for the complex add, then growth
    // over the parallel and serial accumulation stages.
    function automatic int acc_in_bits(input int bitwidth,
                                       input int p_factor_bits,
                                       input int serial_acc_len_bits);
        return 2 * bitwidth + 1 + p_factor_bits + serial_acc_len_bits;
    endfunction

endpackage

// File: rtl/xeng_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head; a push into a full FIFO
// is accepted only when a pop happens in the same cycle.
module xeng_sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_BITS:0]   level_o
);

    localparam int                DEPTH      = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_LEVEL = (DEPTH_BITS + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]   level_q, level_d;
    logic                  do_push, do_pop;

    assign do_pop  = pop_i && (level_q != '0);
    assign do_push = push_i && ((level_q != FULL_LEVEL) || do_pop);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q + (DEPTH_BITS + 1)'(do_push) - (DEPTH_BITS + 1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

endmodule

// File: rtl/xeng_acc_unload.sv
// X-engine accumulator unload: buffers MAC vectors and streams them as four
// narrowed complex beats. Define XENG_ACC_UNLOAD_SAT_EN for symmetric saturation.
module xeng_acc_unload
    import xeng_pkg::*;
#(
    parameter int BITWIDTH            = 4,
    parameter int P_FACTOR_BITS       = 3,
    parameter int SERIAL_ACC_LEN_BITS = 7,
    parameter int OUT_BITS            = 16,
    parameter int FIFO_DEPTH_BITS     = 2,
    parameter int NUM_BASELINES       = 8,
    localparam int ACC_IN_BITS = acc_in_bits(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS),
    localparam int BL_BITS     = (NUM_BASELINES > 1) ? $clog2(NUM_BASELINES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*ACC_IN_BITS-1:0] acc_in_i,
    input  logic                     acc_valid_i,
    output logic [2*OUT_BITS-1:0]    out_data_o,
    output logic [1:0]               out_pol_o,
    output logic [BL_BITS-1:0]       out_baseline_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     ovf_o,
    output logic                     sat_o
);

    localparam int                   PROD_BITS  = 2 * ACC_IN_BITS;
    localparam logic [BL_BITS-1:0]   BL_LAST    = BL_BITS'(NUM_BASELINES - 1);
    localparam logic [FIFO_DEPTH_BITS:0] LEVEL_ONE = (FIFO_DEPTH_BITS + 1)'(1);

    typedef enum logic {S_IDLE, S_SEND} state_e;

    state_e                   state_q, state_d;
    logic [1:0]               beat_q, beat_d;
    logic [BL_BITS-1:0]       bl_q, bl_d;
    logic                     ovf_q, ovf_d;

    logic                     push, pop;
    logic                     fifo_full, fifo_empty;
    logic [8*ACC_IN_BITS-1:0] head;
    logic [FIFO_DEPTH_BITS:0] level;

    // A capture on a full FIFO still lands if the serialiser frees a slot this cycle.
    assign push = acc_valid_i && (!fifo_full || pop);

    xeng_sync_fifo #(
        .WIDTH      (8 * ACC_IN_BITS),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (acc_in_i),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    // XX sits in the most significant product slot, so beat 0 takes the top chunk.
    logic [1:0]                    chunk_idx;
    logic [PROD_BITS-1:0]          prod;
    logic signed [ACC_IN_BITS-1:0] part_re, part_im;

    assign chunk_idx = POL_YX - beat_q;
    assign prod      = head[chunk_idx*PROD_BITS +: PROD_BITS];
    assign part_re   = prod[PROD_BITS-1:ACC_IN_BITS];
    assign part_im   = prod[ACC_IN_BITS-1:0];

`ifdef XENG_ACC_UNLOAD_SAT_EN
    localparam logic signed [ACC_IN_BITS-1:0] SAT_MAX = ACC_IN_BITS'((1 << (OUT_BITS - 1)) - 1);
    localparam logic signed [ACC_IN_BITS-1:0] SAT_MIN = -SAT_MAX;

    function automatic logic [OUT_BITS-1:0] narrow(input logic signed [ACC_IN_BITS-1:0] v);
        if (v > SAT_MAX) return OUT_BITS'(SAT_MAX);
        if (v < SAT_MIN) return OUT_BITS'(SAT_MIN);
        return OUT_BITS'(v);
    endfunction

    logic clamp;
    logic sat_q, sat_d;

    assign clamp = out_valid_o && ((part_re > SAT_MAX) || (part_re < SAT_MIN) ||
                                   (part_im > SAT_MAX) || (part_im < SAT_MIN));
    assign sat_d = sat_q || clamp;

    always_ff @(posedge clk) begin
        if (rst) sat_q <= 1'b0;
        else     sat_q <= sat_d;
    end

    assign sat_o = sat_q;
`else
    function automatic logic [OUT_BITS-1:0] narrow(input logic signed [ACC_IN_BITS-1:0] v);
        return OUT_BITS'(v);
    endfunction

    assign sat_o = 1'b0;
`endif

    // NOTE: every variable driven here gets a default first so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        bl_d    = bl_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_SEND;
                    beat_d  = POL_XX;
                end
            end
            S_SEND: begin
                if (out_ready_i) begin
                    if (beat_q == POL_YX) begin
                        pop    = 1'b1;
                        beat_d = POL_XX;
                        bl_d   = (bl_q == BL_LAST) ? '0 : bl_q + 1'b1;
                        // Only the vector just sent remains and nothing new arrives.
                        if ((level == LEVEL_ONE) && !acc_valid_i) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ovf_d = ovf_q || (acc_valid_i && fifo_full && !pop);
    end

    // NOTE: state registers use non-blocking assignments; combinational logic above uses blocking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            bl_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            bl_q    <= bl_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid_o    = (state_q == S_SEND);
    assign out_data_o     = out_valid_o ? {narrow(part_re), narrow(part_im)} : '0;
    assign out_pol_o      = out_valid_o ? beat_q : '0;
    assign out_baseline_o = out_valid_o ? bl_q : '0;
    assign out_last_o     = out_valid_o && (beat_q == POL_YX) && (bl_q == BL_LAST);
    assign ovf_o          = ovf_q;

endmodule

// File: tb/tb_xeng_acc_unload.sv
// Directed bench for xeng_acc_unload: scoreboard of expected beats filled as
// vectors are driven and drained by a monitor on accepted beats.
module tb_xeng_acc_unload;

    localparam int A   = 19;
    localparam int OUT = 16;
    localparam int NBL = 8;
    localparam int BLB = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [8*A-1:0]   acc_in = '0;
    logic             acc_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [2*OUT-1:0] out_data;
    logic [1:0]       out_pol;
    logic [BLB-1:0]   out_baseline;
    logic             out_last;
    logic             out_valid;
    logic             ovf;
    logic             sat;

    always #5 clk = ~clk;

    xeng_acc_unload dut (
        .clk            (clk),
        .rst            (rst),
        .acc_in_i       (acc_in),
        .acc_valid_i    (acc_valid),
        .out_data_o     (out_data),
        .out_pol_o      (out_pol),
        .out_baseline_o (out_baseline),
        .out_last_o     (out_last),
        .out_valid_o    (out_valid),
        .out_ready_i    (out_ready),
        .ovf_o          (ovf),
        .sat_o          (sat)
    );

    typedef struct packed {
        logic [2*OUT-1:0] data;
        logic [1:0]       pol;
        logic [BLB-1:0]   bl;
        logic             last;
    } beat_t;

    typedef int vec_t [8];

    beat_t sb [$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    n_beats = 0;
    int    n_last  = 0;
    int    exp_bl  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT-1:0] exp_part(input int v);
`ifdef XENG_ACC_UNLOAD_SAT_EN
        if (v > 32767)  return 16'sd32767;
        if (v < -32767) return -16'sd32767;
`endif
        return OUT'(v);
    endfunction

    function automatic int rand_part();
        return int'($urandom_range(0, (1 << A) - 1)) - (1 << (A - 1));
    endfunction

    task automatic drive_vec(input vec_t v, input bit accept);
        logic [8*A-1:0] acc;
        acc = '0;
        for (int p = 0; p < 4; p++) begin
            acc[(3 - p)*2*A + A +: A] = A'(v[2*p]);
            acc[(3 - p)*2*A     +: A] = A'(v[2*p + 1]);
        end
        @(posedge clk); #1;
        acc_in    = acc;
        acc_valid = 1'b1;
        if (accept) begin
            for (int p = 0; p < 4; p++) begin
                sb.push_back('{data: {exp_part(v[2*p]), exp_part(v[2*p + 1])},
                               pol:  2'(p),
                               bl:   BLB'(exp_bl),
                               last: (p == 3) && (exp_bl == NBL - 1)});
            end
            exp_bl = (exp_bl + 1) % NBL;
        end
        @(posedge clk); #1;
        acc_valid = 1'b0;
    endtask

    task automatic reset_dut();
        @(posedge clk); #1;
        out_ready = 1'b0;
        acc_valid = 1'b0;
        rst       = 1'b1;
        sb.delete();
        exp_bl    = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_pol(input logic [1:0] p, input string tag);
        int i;
        i = 0;
        @(negedge clk);
        while (!(out_valid === 1'b1 && out_pol === p) && i < 100) begin
            @(negedge clk);
            i++;
        end
        check(tag, {out_valid, out_pol}, {1'b1, p});
    endtask

    task automatic wait_drain(input string tag);
        int i;
        i = 0;
        while (sb.size() != 0 && i < 400) begin
            @(negedge clk);
            i++;
        end
        check(tag, sb.size(), 0);
        @(negedge clk);
    endtask

    // Every accepted beat must match the oldest expected beat.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            n_beats++;
            if (out_last === 1'b1) n_last++;
            if (sb.size() == 0) begin
                check("spurious_beat", out_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_pol", out_pol, e.pol);
                check("beat_baseline", out_baseline, e.bl);
                check("beat_last", out_last, e.last);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   nb0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", out_data, '0);
        check("rst_pol", out_pol, '0);
        check("rst_baseline", out_baseline, '0);
        check("rst_last", out_last, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_sat", sat, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        // Single vector and latency
        out_ready = 1'b1;
        v = '{1, -1, 2, -2, 3, -3, 4, -4};
        drive_vec(v, 1'b1);
        @(negedge clk);
        check("lat_n1_valid", out_valid, 1'b0);
        @(negedge clk);
        check("lat_n2_valid", out_valid, 1'b1);
        check("lat_n2_pol", out_pol, 2'd0);
        check("single_xx_data", out_data, {16'd1, 16'hFFFF});
        wait_drain("single_drain");

        // Baseline wrap over nine vectors
        reset_dut();
        out_ready = 1'b1;
        n_last = 0;
        for (int k = 0; k < 9; k++) begin
            for (int j = 0; j < 8; j++) v[j] = rand_part();
            drive_vec(v, 1'b1);
            repeat (2) @(posedge clk);
        end
        wait_drain("wrap_drain");
        check("wrap_last_count", n_last, 1);

        // Backpressure on the YY beat
        reset_dut();
        nb0 = n_beats;
        v = '{100, -200, 300, -400, 500, -600, 700, -800};
        drive_vec(v, 1'b1);
        wait_pol(2'd0, "bp_xx_shown");
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_pol", out_pol, 2'd1);
            check("bp_hold_data", out_data, {16'd300, 16'hFE70});
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_beat_count", n_beats - nb0, 4);

        // Overflow: fifth vector into a full FIFO is dropped
        reset_dut();
        nb0 = n_beats;
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 8; j++) v[j] = rand_part();
            drive_vec(v, k < 4);
            if (k == 3) begin
                @(negedge clk);
                check("ovf_clear_at_4", ovf, 1'b0);
            end
        end
        @(negedge clk);
        check("ovf_set", ovf, 1'b1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_drain("ovf_drain");
        repeat (10) @(negedge clk);
        check("ovf_beat_count", n_beats - nb0, 16);
        check("ovf_idle_valid", out_valid, 1'b0);
        check("ovf_sticky", ovf, 1'b1);

        // Narrowing of out-of-range parts
        reset_dut();
        out_ready = 1'b1;
        v = '{70000, -70000, 5, 6, 7, 8, 9, 10};
        drive_vec(v, 1'b1);
        wait_pol(2'd0, "narrow_xx_shown");
`ifdef XENG_ACC_UNLOAD_SAT_EN
        check("narrow_re", out_data[31:16], 16'd32767);
        check("narrow_im", out_data[15:0], 16'h8001);
`else
        check("narrow_re", out_data[31:16], 16'd4464);
        check("narrow_im", out_data[15:0], 16'hEE90);
`endif
        wait_drain("narrow_drain");
`ifdef XENG_ACC_UNLOAD_SAT_EN
        check("sat_flag", sat, 1'b1);
`else
        check("sat_flag", sat, 1'b0);
`endif

        // Reset during the XY beat
        reset_dut();
        out_ready = 1'b1;
        v = '{11, 12, 13, 14, 15, 16, 17, 18};
        drive_vec(v, 1'b1);
        wait_pol(2'd1, "mr_yy_shown");
        @(posedge clk); #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        sb.delete();
        exp_bl    = 0;
        @(negedge clk);
        check("mr_xy_shown", out_pol, 2'd2);
        @(posedge clk);
        @(negedge clk);
        check("mr_valid", out_valid, 1'b0);
        check("mr_data", out_data, '0);
        check("mr_pol", out_pol, '0);
        check("mr_baseline", out_baseline, '0);
        check("mr_last", out_last, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        v = '{-21, 22, -23, 24, -25, 26, -27, 28};
        drive_vec(v, 1'b1);
        wait_pol(2'd0, "mr_restart_xx");
        check("mr_restart_baseline", out_baseline, '0);
        wait_drain("mr_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
